// File: rtl/fde_pkg.sv
// ----------------------------------------------------------------------------
// fde_pkg
// Shared definitions for the fetch/decode/execute phase machine.
//   - fde_state_e     : phase codes (FETCH, DECODE, EXECUTE, HALT)
//   - fde_next_state  : phase successor for one advancing clock edge
// ----------------------------------------------------------------------------
package fde_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        DECODE  = 2'b01,
        EXECUTE = 2'b10,
        HALT    = 2'b11
    } fde_state_e;

    // Successor phase for one advancing edge. A halt request only matters
    // when leaving EXECUTE, and HALT is absorbing.
    function automatic fde_state_e fde_next_state(input fde_state_e cur,
                                                  input logic       halt_req);
        fde_state_e nxt;
        case (cur)
            FETCH:   nxt = DECODE;
            DECODE:  nxt = EXECUTE;
            EXECUTE: nxt = halt_req ? HALT : FETCH;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fde_counter.sv
// ----------------------------------------------------------------------------
// fde_counter
// CNT_W-bit enabled counter that wraps from all-ones to zero silently.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the count
//   inc   : add one on this edge
//   count : current count value (registered)
// ----------------------------------------------------------------------------
module fde_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register: clear on reset, step on inc, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fde_machine.sv
// ----------------------------------------------------------------------------
// fde_machine
// Three-phase instruction sequencer: FETCH -> DECODE -> EXECUTE -> FETCH,
// with an absorbing HALT phase entered when a halt request is seen while
// EXECUTE advances. Counts retired instructions.
// Ports:
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset (priority over everything)
//   en            : advance enable; low freezes all state
//   stall         : holds the current phase while high
//   halt          : halt request, only looked at in EXECUTE
//   state         : current phase code
//   fetch_strobe  : high in FETCH
//   decode_strobe : high in DECODE
//   exec_strobe   : high in EXECUTE
//   instr_done    : one-cycle pulse after each EXECUTE advance
//   instr_count   : retired-instruction count, wraps silently
//   halted        : high in HALT
// ----------------------------------------------------------------------------
module fde_machine
    import fde_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             stall,
    input  logic             halt,
    output logic [1:0]       state,
    output logic             fetch_strobe,
    output logic             decode_strobe,
    output logic             exec_strobe,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted
);

    fde_state_e state_r;
    fde_state_e next_state_s;
    logic       advance_s;
    logic       retire_s;
    logic       instr_done_r;
    logic       fetch_strobe_s;
    logic       decode_strobe_s;
    logic       exec_strobe_s;
    logic       halted_s;

    // An edge only moves the machine when enabled and not stalled.
    assign advance_s = en & ~stall;

    // An instruction retires on the edge that advances out of EXECUTE,
    // whether it goes back to FETCH or into HALT.
    assign retire_s = advance_s & (state_r == EXECUTE);

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        if (advance_s) begin
            next_state_s = fde_next_state(state_r, halt);
        end else begin
            next_state_s = state_r;
        end
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retire pulse register: high for the one cycle following a retirement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_done_r <= 1'b0;
        end else begin
            instr_done_r <= retire_s;
        end
    end

    // Retired-instruction counter steps on the same edge the pulse rises.
    fde_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire_s),
        .count (instr_count)
    );

    // Output decode of the phase register; exactly one output is high.
    always_comb begin
        fetch_strobe_s  = 1'b0;
        decode_strobe_s = 1'b0;
        exec_strobe_s   = 1'b0;
        halted_s        = 1'b0;
        case (state_r)
            FETCH:   fetch_strobe_s  = 1'b1;
            DECODE:  decode_strobe_s = 1'b1;
            EXECUTE: exec_strobe_s   = 1'b1;
            HALT:    halted_s        = 1'b1;
            default: fetch_strobe_s  = 1'b1;
        endcase
    end

    assign state         = state_r;
    assign fetch_strobe  = fetch_strobe_s;
    assign decode_strobe = decode_strobe_s;
    assign exec_strobe   = exec_strobe_s;
    assign halted        = halted_s;
    assign instr_done    = instr_done_r;

endmodule

// File: tb/tb_fde_machine.sv
// ----------------------------------------------------------------------------
// tb_fde_machine
// Scoreboard bench for fde_machine. Two instances (default width and a
// 4-bit counter) share the same inputs. A behavioural model tracks which
// step of an instruction is current, whether the machine has stopped and
// how many instructions have retired; expected results are queued per edge
// and a monitor compares them after each rising edge.
// ----------------------------------------------------------------------------
module tb_fde_machine;
    import fde_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;

    logic [1:0]  state_a, state_b;
    logic        fs_a, ds_a, es_a, done_a, halted_a;
    logic        fs_b, ds_b, es_b, done_b, halted_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    fde_machine dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .halt(halt),
        .state(state_a), .fetch_strobe(fs_a), .decode_strobe(ds_a),
        .exec_strobe(es_a), .instr_done(done_a), .instr_count(cnt_a),
        .halted(halted_a)
    );

    fde_machine #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .halt(halt),
        .state(state_b), .fetch_strobe(fs_b), .decode_strobe(ds_b),
        .exec_strobe(es_b), .instr_done(done_b), .instr_count(cnt_b),
        .halted(halted_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       done;
        int unsigned retired;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int          m_step    = 0;   // 0,1,2 = fetch/decode/execute step
    bit          m_stopped = 1'b0;
    int unsigned m_retired = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] model_code();
        if (m_stopped) return HALT;
        case (m_step)
            0:       return FETCH;
            1:       return DECODE;
            default: return EXECUTE;
        endcase
    endfunction

    // Drive one edge's inputs, update the model, queue the expectation.
    task automatic step(input bit r, input bit e, input bit s, input bit h);
        exp_t x;
        bit   d;
        rst_n = r; en = e; stall = s; halt = h;
        d = 1'b0;
        if (!r) begin
            m_step = 0; m_stopped = 1'b0; m_retired = 0;
        end else if (e && !s && !m_stopped) begin
            if (m_step == 2) begin
                m_retired++;
                d = 1'b1;
                if (h) m_stopped = 1'b1;
                else   m_step = 0;
            end else begin
                m_step++;
            end
        end
        x.st = model_code();
        x.done = d;
        x.retired = m_retired;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compare every queued expectation just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("state",        state_a,  x.st);
                check("state_w4",     state_b,  x.st);
                check("fetch_strobe", fs_a,     x.st == FETCH);
                check("decode_strobe",ds_a,     x.st == DECODE);
                check("exec_strobe",  es_a,     x.st == EXECUTE);
                check("halted",       halted_a, x.st == HALT);
                check("onehot_w4",    {fs_b, ds_b, es_b, halted_b},
                      {x.st == FETCH, x.st == DECODE, x.st == EXECUTE, x.st == HALT});
                check("instr_done",   done_a,   x.done);
                check("instr_done_w4",done_b,   x.done);
                check("instr_count",  cnt_a,    x.retired % 65536);
                check("instr_count_w4", cnt_b,  x.retired % 16);
            end
        end
    end

    initial begin
        @(negedge clk);
        // reset, then idle with en low
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        // six free-running edges: two instructions
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        // stall three edges in DECODE, then advance
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        // halt while leaving EXECUTE, then stay halted
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        // halt ignored in FETCH/DECODE; 16 instructions wrap the 4-bit count
        for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 1'b0, (i % 3) != 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        // reset while in EXECUTE with halt high: no retire
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 19) == 0);
        end
        // let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fde_machine.md
FDE_MACHINE -- requirements
Module: fde_machine

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the retired-instruction counter.
REQ-002 Port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port en, input, 1 bit: advance enable; low freezes all state and counters.
REQ-005 Port stall, input, 1 bit: holds the current phase while high, even with en high.
REQ-006 Port halt, input, 1 bit: halt request, sampled only in EXECUTE.
REQ-007 Port state, output, 2 bits: current phase code.
REQ-008 Ports fetch_strobe, decode_strobe, exec_strobe, outputs, 1 bit each: one-hot decode of state, forced low in HALT.
REQ-009 Port instr_done, output, 1 bit: single-cycle pulse when an EXECUTE phase completes.
REQ-010 Port instr_count, output, CNT_W bits: number of retired instructions.
REQ-011 Port halted, output, 1 bit: high while state is HALT.

Function
REQ-012 The state encoding SHALL be FETCH=2'b00, DECODE=2'b01, EXECUTE=2'b10, HALT=2'b11.
REQ-013 The phase SHALL advance on a rising edge only when en=1 and stall=0, following FETCH->DECODE->EXECUTE->FETCH.
REQ-014 With en=0 or stall=1, state, instr_count and the registered outputs SHALL hold their values, and instr_done SHALL be 0.
REQ-015 When EXECUTE advances with halt=1, the next state SHALL be HALT; with halt=0, the next state SHALL be FETCH.
REQ-016 HALT SHALL be absorbing; only rst_n=0 exits it.
REQ-017 halt SHALL be ignored in FETCH and DECODE.
REQ-018 instr_done SHALL be a registered pulse, high for exactly one cycle after each EXECUTE advance, including the advance into HALT.
REQ-019 instr_count SHALL increment by 1 in the same cycle instr_done rises.
REQ-020 instr_count SHALL wrap from all-ones to 0 with no flag.
REQ-021 The strobe outputs and halted SHALL be combinational decodes of state; exactly one of fetch_strobe, decode_strobe, exec_strobe, halted SHALL be high at any time.
REQ-022 Each phase SHALL last exactly one cycle when en=1 and stall=0; a full instruction takes 3 cycles.
REQ-023 Latency from en rising to the first state change SHALL be one clock edge.
REQ-024 No output SHALL be X after the first reset edge.

Reset
REQ-025 When rst_n=0 at a rising edge, the following SHALL apply: state=FETCH, instr_count=0, instr_done=0.
REQ-026 Reset SHALL take priority over en, stall and halt, and SHALL apply mid-phase and in HALT.
REQ-027 Outputs SHALL be undefined before the first reset edge; benches SHALL apply reset first.

Structure
REQ-028 The state codes FETCH, DECODE, EXECUTE and HALT SHALL be defined as named constants in a shared header/package (fde_pkg) used by the RTL and the bench.
REQ-029 The block SHALL be one module with separate next-state, state-register, counter and output-decode sections.
REQ-030 An optional sub-module fde_counter (CNT_W-bit enabled wrap counter) MAY hold instr_count.

Verification
REQ-031 Reset then en=0 for 2 cycles -> state=00 throughout, instr_count=0, fetch_strobe=1.
REQ-032 en=1, stall=0, halt=0 for 6 cycles -> state sequence 01,10,00,01,10,00; instr_done pulses twice; instr_count=2.
REQ-033 en=1, stall raised for 3 cycles in DECODE -> state stays 01 for 3 cycles, then 10.
REQ-034 halt=1 during EXECUTE -> state=11, halted=1, all strobes 0; state stays 11 for 5 cycles with en=1; rst_n=0 for 1 edge -> state=00, instr_count=0.
REQ-035 CNT_W=4, run 16 instructions -> instr_count wraps from 4'hF to 4'h0.
REQ-036 rst_n=0 asserted while in EXECUTE with halt=1 -> next state=00, no instr_done pulse.
